// File: rtl/ntt_pkg.sv
// ntt_pkg: shared state encoding, default sizing constants and the
// bit-reversal helper used when loading coefficients.
package ntt_pkg;

   localparam int NTT_W = 16;
   localparam int NTT_N = 8;
   localparam int NTT_Q = 17;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_PREP   = 3'd2,
      ST_BFLY   = 3'd3,
      ST_SCALE  = 3'd4,
      ST_UNLOAD = 3'd5
   } ntt_state_e;

   // Reverse the low 'bits' bits of k; upper bits of the result stay zero.
   function automatic logic [7:0] bitrev(input logic [7:0] k, input int bits);
      logic [7:0] r;
      r = 8'd0;
      for (int i = 0; i < bits; i++) begin
         r[bits - 1 - i] = k[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/ntt_butterfly.sv
// ntt_butterfly: combinational modular butterfly.
//   t = w*b mod Q, a_new = (a+t) mod Q, b_new = (a-t+Q) mod Q.
// Operands must already be below Q. With a = 0 the block is a plain
// modular multiplier (a_new = w*b mod Q), which the engine relies on.
module ntt_butterfly #(
   parameter int W = 16,
   parameter int Q = 17
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] w,
   output logic [W-1:0] a_new,
   output logic [W-1:0] b_new
);

   logic [2*W-1:0] prod_s;
   logic [W-1:0]   t_s;
   logic [W:0]     sum_s;
   logic [W:0]     dif_s;

   // Full-width product, reduction, then single-subtract correction of sum/difference.
   always_comb begin
      prod_s = {{W{1'b0}}, b} * {{W{1'b0}}, w};
      t_s    = W'(prod_s % (2*W)'(Q));
      sum_s  = {1'b0, a} + {1'b0, t_s};
      dif_s  = {1'b0, a} + (W+1)'(Q) - {1'b0, t_s};
      if (sum_s >= (W+1)'(Q)) begin
         a_new = W'(sum_s - (W+1)'(Q));
      end else begin
         a_new = W'(sum_s);
      end
      if (dif_s >= (W+1)'(Q)) begin
         b_new = W'(dif_s - (W+1)'(Q));
      end else begin
         b_new = W'(dif_s);
      end
   end

endmodule

// File: rtl/ntt_engine.sv
// ntt_engine: in-place iterative Cooley-Tukey number-theoretic transform.
// Coefficients are loaded in bit-reversed order, a stage-root table is built
// by repeated squaring, butterflies run one per cycle, and results stream out
// in natural order with valid/ready handshakes.
// Optional inverse transform (inv port, ROOT_INV, N_INV scaling, SCALE state)
// is compiled in when the macro NTT_INVERSE_EN is defined.
module ntt_engine
   import ntt_pkg::*;
#(
   parameter int W        = NTT_W,
   parameter int N        = NTT_N,
   parameter int Q        = NTT_Q,
   parameter int ROOT     = 2,
   parameter int ROOT_INV = 9,
   parameter int N_INV    = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
`ifdef NTT_INVERSE_EN
   input  logic         inv,
`endif
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   output logic         in_ready,
   output logic         out_valid,
   output logic [W-1:0] out_data,
   input  logic         out_ready,
   output logic         busy,
   output logic         done,
   output logic [15:0]  cycles
);

   localparam int LOGN = $clog2(N);
   localparam int AW   = LOGN;
   localparam int SW   = (LOGN > 1) ? $clog2(LOGN) : 1;

   ntt_state_e    state_r, next_s;
   logic [AW-1:0] cnt_r;
   logic [SW-1:0] stage_r;
   logic [W-1:0]  w_r, prev_r;
   logic [W-1:0]  tab_r [LOGN];
   logic [W-1:0]  mem_r [N];
   logic [15:0]   cyc_r, cycles_r;
`ifdef NTT_INVERSE_EN
   logic          inv_r;
`else
   logic          unused_inv_s;
`endif

   logic          cnt_last_n_s, cnt_last_prep_s, cnt_last_half_s, stage_last_s;
   logic [AW-1:0] jmask_s, jj_s, idx_a_s, idx_b_s, ld_idx_s;
   logic [SW-1:0] ptab_idx_s;
   logic [W-1:0]  w_cur_s, root_s, sq_s, ld_val_s;
   logic [W-1:0]  bf_a_in_s, bf_b_in_s, bf_w_in_s, bf_a_out_s, bf_b_out_s;
   logic [W-1:0]  ax_b_in_s, ax_w_in_s, ax_a_out_s, ax_b_unused_s;

`ifndef NTT_INVERSE_EN
   // Inverse-only parameters have no function in a forward-only build.
   assign unused_inv_s = (ROOT_INV == 32'sd0) ^ (N_INV == 32'sd0);
`endif

   // Counter terminal flags, butterfly addressing and load address/value.
   always_comb begin
      cnt_last_n_s    = (cnt_r == AW'(N - 1));
      cnt_last_prep_s = (cnt_r == AW'(LOGN - 1));
      cnt_last_half_s = (cnt_r == AW'(N / 2 - 1));
      stage_last_s    = (stage_r == SW'(LOGN - 1));
      jmask_s         = (AW'(1'b1) << stage_r) - AW'(1'b1);
      jj_s            = cnt_r & jmask_s;
      idx_a_s         = ((cnt_r & ~jmask_s) << 1) | jj_s;
      idx_b_s         = idx_a_s | (AW'(1'b1) << stage_r);
      ld_idx_s        = AW'(bitrev(8'(cnt_r), LOGN));
      ld_val_s        = in_data % W'(Q);
      ptab_idx_s      = SW'(LOGN - 1) - SW'(cnt_r);
      if (jj_s == {AW{1'b0}}) begin
         w_cur_s = W'(1'b1);
      end else begin
         w_cur_s = w_r;
      end
`ifdef NTT_INVERSE_EN
      if (inv_r) begin
         root_s = W'(ROOT_INV);
      end else begin
         root_s = W'(ROOT);
      end
`else
      root_s = W'(ROOT);
`endif
      if (cnt_r == {AW{1'b0}}) begin
         sq_s = root_s;
      end else begin
         sq_s = ax_a_out_s;
      end
   end

   // Data butterfly operands; in SCALE it becomes a multiply by N^-1.
   always_comb begin
      bf_a_in_s = mem_r[idx_a_s];
      bf_b_in_s = mem_r[idx_b_s];
      bf_w_in_s = w_cur_s;
`ifdef NTT_INVERSE_EN
      if (state_r == ST_SCALE) begin
         bf_a_in_s = {W{1'b0}};
         bf_b_in_s = mem_r[cnt_r];
         bf_w_in_s = W'(N_INV);
      end else begin
         bf_a_in_s = mem_r[idx_a_s];
      end
`endif
   end

   // Auxiliary multiplier: root squaring in PREP, twiddle advance in BFLY.
   always_comb begin
      if (state_r == ST_PREP) begin
         ax_b_in_s = prev_r;
         ax_w_in_s = prev_r;
      end else begin
         ax_b_in_s = w_cur_s;
         ax_w_in_s = tab_r[stage_r];
      end
   end

   ntt_butterfly #(.W(W), .Q(Q)) u_bfly (
      .a     (bf_a_in_s),
      .b     (bf_b_in_s),
      .w     (bf_w_in_s),
      .a_new (bf_a_out_s),
      .b_new (bf_b_out_s)
   );

   ntt_butterfly #(.W(W), .Q(Q)) u_aux (
      .a     ({W{1'b0}}),
      .b     (ax_b_in_s),
      .w     (ax_w_in_s),
      .a_new (ax_a_out_s),
      .b_new (ax_b_unused_s)
   );

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state logic; start is only looked at in IDLE.
   always_comb begin
      next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) next_s = ST_LOAD;
            else       next_s = ST_IDLE;
         end
         ST_LOAD: begin
            if (in_valid && cnt_last_n_s) next_s = ST_PREP;
            else                          next_s = ST_LOAD;
         end
         ST_PREP: begin
            if (cnt_last_prep_s) next_s = ST_BFLY;
            else                 next_s = ST_PREP;
         end
         ST_BFLY: begin
            if (cnt_last_half_s && stage_last_s) begin
`ifdef NTT_INVERSE_EN
               if (inv_r) next_s = ST_SCALE;
               else       next_s = ST_UNLOAD;
`else
               next_s = ST_UNLOAD;
`endif
            end else begin
               next_s = ST_BFLY;
            end
         end
`ifdef NTT_INVERSE_EN
         ST_SCALE: begin
            if (cnt_last_n_s) next_s = ST_UNLOAD;
            else              next_s = ST_SCALE;
         end
`endif
         ST_UNLOAD: begin
            if (out_ready && cnt_last_n_s) next_s = ST_IDLE;
            else                           next_s = ST_UNLOAD;
         end
         default: next_s = ST_IDLE;
      endcase
   end

   // Datapath: counters, coefficient memory, root table and cycle accounting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_r    <= {AW{1'b0}};
         stage_r  <= {SW{1'b0}};
         w_r      <= {W{1'b0}};
         prev_r   <= {W{1'b0}};
         cyc_r    <= 16'd0;
         cycles_r <= 16'd0;
`ifdef NTT_INVERSE_EN
         inv_r    <= 1'b0;
`endif
         for (int i = 0; i < LOGN; i++) tab_r[i] <= {W{1'b0}};
         for (int i = 0; i < N; i++)    mem_r[i] <= {W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r   <= {AW{1'b0}};
               stage_r <= {SW{1'b0}};
               cyc_r   <= 16'd0;
`ifdef NTT_INVERSE_EN
               if (start) inv_r <= inv;
`endif
            end
            ST_LOAD: begin
               if (in_valid) begin
                  mem_r[ld_idx_s] <= ld_val_s;
                  cnt_r <= cnt_last_n_s ? {AW{1'b0}} : cnt_r + AW'(1'b1);
               end
            end
            ST_PREP: begin
               tab_r[ptab_idx_s] <= sq_s;
               prev_r <= sq_s;
               cyc_r  <= cyc_r + 16'd1;
               cnt_r  <= cnt_last_prep_s ? {AW{1'b0}} : cnt_r + AW'(1'b1);
            end
            ST_BFLY: begin
               mem_r[idx_a_s] <= bf_a_out_s;
               mem_r[idx_b_s] <= bf_b_out_s;
               w_r   <= ax_a_out_s;
               cyc_r <= cyc_r + 16'd1;
               if (cnt_last_half_s) begin
                  cnt_r   <= {AW{1'b0}};
                  stage_r <= stage_last_s ? {SW{1'b0}} : stage_r + SW'(1'b1);
               end else begin
                  cnt_r <= cnt_r + AW'(1'b1);
               end
            end
`ifdef NTT_INVERSE_EN
            ST_SCALE: begin
               mem_r[cnt_r] <= bf_a_out_s;
               cyc_r <= cyc_r + 16'd1;
               cnt_r <= cnt_last_n_s ? {AW{1'b0}} : cnt_r + AW'(1'b1);
            end
`endif
            ST_UNLOAD: begin
               if (out_ready) begin
                  cnt_r <= cnt_last_n_s ? {AW{1'b0}} : cnt_r + AW'(1'b1);
               end
            end
            default: cnt_r <= {AW{1'b0}};
         endcase
         if ((state_r != ST_UNLOAD) && (next_s == ST_UNLOAD)) begin
            cycles_r <= cyc_r + 16'd1;
         end
      end
   end

   // Output decode from the state register; done marks the final accepted word.
   always_comb begin
      in_ready  = (state_r == ST_LOAD);
      out_valid = (state_r == ST_UNLOAD);
      busy      = (state_r != ST_IDLE);
      done      = (state_r == ST_UNLOAD) && out_ready && cnt_last_n_s;
      cycles    = cycles_r;
      if (state_r == ST_UNLOAD) begin
         out_data = mem_r[cnt_r];
      end else begin
         out_data = {W{1'b0}};
      end
   end

endmodule

// File: tb/tb_ntt_engine.sv
// tb_ntt_engine: scoreboard bench for ntt_engine (N=8, Q=17, ROOT=2).
// Expected outputs come from a direct O(N^2) reference transform or from
// known vectors, are queued when a job starts and popped as words leave.
module tb_ntt_engine;

   localparam int TN = 8;
   localparam int TQ = 17;
   localparam int TW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          inv_sig;
   logic          in_valid;
   logic [TW-1:0] in_data;
   logic          in_ready;
   logic          out_valid;
   logic [TW-1:0] out_data;
   logic          out_ready;
   logic          busy;
   logic          done;
   logic [15:0]   cycles;

   int n_checks = 0;
   int n_errors = 0;
   int exp_q[$];

   always #5 clk = ~clk;

   ntt_engine #(.W(16), .N(8), .Q(17), .ROOT(2), .ROOT_INV(9), .N_INV(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
`ifdef NTT_INVERSE_EN
      .inv       (inv_sig),
`endif
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .busy      (busy),
      .done      (done),
      .cycles    (cycles)
   );

   function automatic int modpow(input int b, input int e);
      int r;
      r = 1;
      for (int i = 0; i < e; i++) r = (r * b) % TQ;
      return r;
   endfunction

   // X[k] = sum_n x[n]*r^(n*k) mod Q, scaled by N^-1 for the inverse.
   function automatic void ref_ntt(input int x[TN], input bit inv_b, output int y[TN]);
      int r, acc;
      r = inv_b ? 9 : 2;
      for (int k = 0; k < TN; k++) begin
         acc = 0;
         for (int n = 0; n < TN; n++) acc = (acc + (x[n] % TQ) * modpow(r, n * k)) % TQ;
         y[k] = inv_b ? (acc * 15) % TQ : acc;
      end
   endfunction

   task automatic load_data(input int x[TN], input bit in_rand, input string tag);
      int k = 0;
      int guard = 0;
      while (k < TN && guard < 200) begin
         in_valid = in_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = 16'(x[k]);
         #1;
         if (in_valid && in_ready) k++;
         @(negedge clk);
         guard++;
      end
      in_valid = 1'b0;
      n_checks++;
      if (k != TN) begin
         n_errors++;
         $display("FAIL %s load_count: got %0d words, want %0d", tag, k, TN);
      end
   endtask

   task automatic run_job(input int x[TN], input int y[TN], input bit inv_b, input bit in_rand,
                          input bit out_rand, input bit poke, input int exp_cyc, input string tag);
      int guard, got, e;
      logic [TW-1:0] held;
      logic exp_done;
      bit hold_v;
      for (int i = 0; i < TN; i++) exp_q.push_back(y[i]);
      @(negedge clk);
      start = 1'b1;
      inv_sig = inv_b;
      @(negedge clk);
      start = 1'b0;
      load_data(x, in_rand, tag);
      if (poke) begin
         repeat (4) @(negedge clk);
         start = 1'b1;
         #1;
         n_checks++;
         if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s busy_bfly: got %b want 1", tag, busy);
         end
         @(negedge clk);
         start = 1'b0;
      end
      guard = 0;
      while (out_valid !== 1'b1 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL %s out_valid_timeout: got %b want 1", tag, out_valid);
         exp_q.delete();
         return;
      end
      n_checks++;
      if (cycles !== 16'(exp_cyc)) begin
         n_errors++;
         $display("FAIL %s cycles: got %0d want %0d", tag, cycles, exp_cyc);
      end
      got = 0;
      guard = 0;
      hold_v = 1'b0;
      held = 16'd0;
      while (got < TN && guard < 400) begin
         out_ready = out_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         #1;
         n_checks++;
         if (out_valid !== 1'b1 || (hold_v && out_data !== held)) begin
            n_errors++;
            $display("FAIL %s hold: valid %b data %0d want valid 1 data %0d", tag, out_valid, out_data, held);
         end
         exp_done = out_ready && (got == TN - 1);
         n_checks++;
         if (done !== exp_done) begin
            n_errors++;
            $display("FAIL %s done: got %b want %b at word %0d", tag, done, exp_done, got);
         end
         if (out_ready) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            n_checks++;
            if (out_data !== 16'(e)) begin
               n_errors++;
               $display("FAIL %s data[%0d]: got %0d want %0d", tag, got, out_data, e);
            end
            got++;
            hold_v = 1'b0;
         end else begin
            hold_v = 1'b1;
            held = out_data;
         end
         @(negedge clk);
         guard++;
      end
      out_ready = 1'b0;
      n_checks++;
      if (got != TN) begin
         n_errors++;
         $display("FAIL %s unload_count: got %0d want %0d", tag, got, TN);
      end
      #1;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
         n_errors++;
         $display("FAIL %s idle_after: busy %b valid %b done %b want 0 0 0", tag, busy, out_valid, done);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      start = 1'b0;
      inv_sig = 1'b0;
      in_valid = 1'b0;
      in_data = 16'd0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
          out_data !== 16'd0 || cycles !== 16'd0) begin
         n_errors++;
         $display("FAIL reset: rdy %b vld %b busy %b done %b data %0d cyc %0d want all 0",
                  in_ready, out_valid, busy, done, out_data, cycles);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_impulse();
      int x[TN], y[TN];
      for (int i = 0; i < TN; i++) begin
         x[i] = (i == 0) ? 1 : 0;
         y[i] = 1;
      end
      run_job(x, y, 1'b0, 1'b0, 1'b0, 1'b0, 15, "impulse");
   endtask

   task automatic test_dc();
      int x[TN], y[TN];
      for (int i = 0; i < TN; i++) begin
         x[i] = 1;
         y[i] = (i == 0) ? 8 : 0;
      end
      run_job(x, y, 1'b0, 1'b0, 1'b0, 1'b0, 15, "dc");
   endtask

   // Random full-range words also exercise reduction of inputs >= Q.
   task automatic test_random_vec();
      int x[TN], y[TN];
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < TN; i++) x[i] = int'($urandom_range(0, 65535));
         ref_ntt(x, 1'b0, y);
         run_job(x, y, 1'b0, 1'b0, 1'b0, 1'b0, 15, "random");
      end
   endtask

   task automatic test_backpressure();
      int x[TN], y[TN];
      for (int i = 0; i < TN; i++) begin
         x[i] = (i == 0) ? 1 : 0;
         y[i] = 1;
      end
      run_job(x, y, 1'b0, 1'b1, 1'b1, 1'b0, 15, "bp_impulse");
      for (int i = 0; i < TN; i++) x[i] = int'($urandom_range(0, 40));
      ref_ntt(x, 1'b0, y);
      run_job(x, y, 1'b0, 1'b1, 1'b1, 1'b0, 15, "bp_random");
   endtask

   task automatic test_start_ignored();
      int x[TN], y[TN];
      for (int i = 0; i < TN; i++) begin
         x[i] = (i == 0) ? 1 : 0;
         y[i] = 1;
      end
      run_job(x, y, 1'b0, 1'b0, 1'b0, 1'b1, 15, "start_in_bfly");
   endtask

   task automatic test_abort();
      int x[TN], y[TN];
      for (int i = 0; i < TN; i++) begin
         x[i] = 1;
         y[i] = 1;
      end
      @(negedge clk);
      start = 1'b1;
      inv_sig = 1'b0;
      @(negedge clk);
      start = 1'b0;
      load_data(x, 1'b0, "abort");
      repeat (5) @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 ||
          cycles !== 16'd0 || out_data !== 16'd0) begin
         n_errors++;
         $display("FAIL abort_reset: busy %b vld %b rdy %b done %b cyc %0d data %0d want all 0",
                  busy, out_valid, in_ready, done, cycles, out_data);
      end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < TN; i++) x[i] = (i == 0) ? 1 : 0;
      run_job(x, y, 1'b0, 1'b0, 1'b0, 1'b0, 15, "after_abort");
   endtask

`ifdef NTT_INVERSE_EN
   task automatic test_roundtrip();
      int x[TN], f[TN];
      x = '{1, 2, 3, 4, 0, 0, 0, 0};
      ref_ntt(x, 1'b0, f);
      run_job(x, f, 1'b0, 1'b0, 1'b0, 1'b0, 15, "rt_forward");
      run_job(f, x, 1'b1, 1'b0, 1'b1, 1'b0, 23, "rt_inverse");
   endtask
`endif

   initial begin
      test_reset();
      test_impulse();
      test_dc();
      test_random_vec();
      test_backpressure();
      test_start_ignored();
      test_abort();
`ifdef NTT_INVERSE_EN
      test_roundtrip();
`endif
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
